sync_fifo_param: RTL and testbench

//  Single-clock FIFO with parametrised data width and depth, built-in storage and the full

---
 rtl/rs_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 tb/tb_sync_fifo_param.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rs_fifo_pkg.sv
// Shared definitions for the fabric FIFO wrappers: status-flag vector layout and the
// RMODE/WMODE width encodings used across the RAM/FIFO wrapper family.
package rs_fifo_pkg;

  // Flag vector layout, MSB first: {FULL, FMO, FWM, OVERRUN, EMPTY, EPO, EWM, UNDERRUN}
  localparam int unsigned FLAG_UNDERRUN = 0;
  localparam int unsigned FLAG_EWM      = 1;
  localparam int unsigned FLAG_EPO      = 2;
  localparam int unsigned FLAG_EMPTY    = 3;
  localparam int unsigned FLAG_OVERRUN  = 4;
  localparam int unsigned FLAG_FWM      = 5;
  localparam int unsigned FLAG_FMO      = 6;
  localparam int unsigned FLAG_FULL     = 7;
  localparam int unsigned FLAG_NUM      = 8;

  localparam logic [FLAG_NUM-1:0] FLAGS_RESET = 8'b0000_1010;

  localparam logic [2:0] MODE_1  = 3'b101;
  localparam logic [2:0] MODE_2  = 3'b110;
  localparam logic [2:0] MODE_4  = 3'b100;
  localparam logic [2:0] MODE_9  = 3'b001;
  localparam logic [2:0] MODE_18 = 3'b010;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with level count, full eight-flag status set, synchronous flush and an
// optional first-word-fall-through read port.
module sync_fifo_param
  import rs_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned UPAE       = 4,
  parameter int unsigned UPAF       = 4,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  FLUSH_i,
  input  logic                  WEN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  REN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic [ADDR_WIDTH:0]   LEVEL_o,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o,
  output logic                  UNDERRUN_o,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  OVERRUN_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t LvlFull = ptr_t'(Depth);
  localparam ptr_t LvlFmo  = ptr_t'(Depth - 1);
  localparam ptr_t LvlFwm  = ptr_t'(Depth - UPAF);
  localparam ptr_t LvlEwm  = ptr_t'(UPAE);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 36 || ADDR_WIDTH < 2 || ADDR_WIDTH > 14 ||
      UPAE < 1 || UPAE > Depth - 2 || UPAF < 1 || UPAF > Depth - 2) begin : g_param_check
    $error("sync_fifo_param: parameter out of legal range");
  end

  ptr_t                  wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [FLAG_NUM-1:0]   flags_q, flags_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_acc  = WEN_i & ~flags_q[FLAG_FULL] & ~FLUSH_i;
    rd_acc  = REN_i & ~flags_q[FLAG_EMPTY] & ~FLUSH_i;
    wptr_d  = wptr_q + ptr_t'(wr_acc);
    rptr_d  = rptr_q + ptr_t'(rd_acc);
    level_d = wptr_d - rptr_d;

    flags_d                = '0;
    flags_d[FLAG_FULL]     = (level_d == LvlFull);
    flags_d[FLAG_FMO]      = (level_d == LvlFmo);
    flags_d[FLAG_FWM]      = (level_d >= LvlFwm);
    flags_d[FLAG_OVERRUN]  = flags_q[FLAG_OVERRUN] | (WEN_i & flags_q[FLAG_FULL]);
    flags_d[FLAG_EMPTY]    = (level_d == '0);
    flags_d[FLAG_EPO]      = (level_d == ptr_t'(1));
    flags_d[FLAG_EWM]      = (level_d <= LvlEwm);
    flags_d[FLAG_UNDERRUN] = flags_q[FLAG_UNDERRUN] | (REN_i & flags_q[FLAG_EMPTY]);

    // Flush wins over any request in the same cycle, including sticky-flag updates.
    if (FLUSH_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      flags_d = FLAGS_RESET;
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      flags_q <= flags_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (CLK_i),
    .we    (wr_acc),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (WDATA_i),
    .raddr (rptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    // Storage is never reset, so mask the head word while empty to present zero.
    assign RDATA_o = flags_q[FLAG_EMPTY] ? '0 : mem_rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
        rdata_q <= '0;
      end else if (FLUSH_i) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= mem_rdata;
      end
    end
    assign RDATA_o = rdata_q;
  end

  assign LEVEL_o    = level_q;
  assign FULL_o     = flags_q[FLAG_FULL];
  assign FMO_o      = flags_q[FLAG_FMO];
  assign FWM_o      = flags_q[FLAG_FWM];
  assign OVERRUN_o  = flags_q[FLAG_OVERRUN];
  assign EMPTY_o    = flags_q[FLAG_EMPTY];
  assign EPO_o      = flags_q[FLAG_EPO];
  assign EWM_o      = flags_q[FLAG_EWM];
  assign UNDERRUN_o = flags_q[FLAG_UNDERRUN];

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: registered-read and FWFT instances of sync_fifo_param share one stimulus.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, flush, wen, ren;
  logic [7:0] wdata;

  logic [7:0] rdata0, rdata1;
  logic [3:0] level0, level1;
  logic       full0, fmo0, fwm0, ovr0, empty0, epo0, ewm0, und0;
  logic       full1, fmo1, fwm1, ovr1, empty1, epo1, ewm1, und1;
  logic [7:0] fl0, fl1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] lvl_fl [9];

  always #5 clk = ~clk;

  assign fl0 = {full0, fmo0, fwm0, ovr0, empty0, epo0, ewm0, und0};
  assign fl1 = {full1, fmo1, fwm1, ovr1, empty1, epo1, ewm1, und1};

  sync_fifo_param #(
    .DATA_WIDTH (8), .ADDR_WIDTH (3), .UPAE (2), .UPAF (2), .FWFT (1'b0)
  ) dut0 (
    .CLK_i (clk), .RST_i (rst), .FLUSH_i (flush), .WEN_i (wen), .WDATA_i (wdata),
    .REN_i (ren), .RDATA_o (rdata0), .LEVEL_o (level0),
    .EMPTY_o (empty0), .EPO_o (epo0), .EWM_o (ewm0), .UNDERRUN_o (und0),
    .FULL_o (full0), .FMO_o (fmo0), .FWM_o (fwm0), .OVERRUN_o (ovr0)
  );

  sync_fifo_param #(
    .DATA_WIDTH (8), .ADDR_WIDTH (3), .UPAE (2), .UPAF (2), .FWFT (1'b1)
  ) dut1 (
    .CLK_i (clk), .RST_i (rst), .FLUSH_i (flush), .WEN_i (wen), .WDATA_i (wdata),
    .REN_i (ren), .RDATA_o (rdata1), .LEVEL_o (level1),
    .EMPTY_o (empty1), .EPO_o (epo1), .EWM_o (ewm1), .UNDERRUN_o (und1),
    .FULL_o (full1), .FMO_o (fmo1), .FWM_o (fwm1), .OVERRUN_o (ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] lvl, input logic [7:0] fl);
    chk({tag, " level0"}, 32'(level0), 32'(lvl));
    chk({tag, " level1"}, 32'(level1), 32'(lvl));
    chk({tag, " flags0"}, 32'(fl0), 32'(fl));
    chk({tag, " flags1"}, 32'(fl1), 32'(fl));
  endtask

  task automatic chk_data(input string tag, input logic [7:0] d0, input logic [7:0] d1);
    chk({tag, " rdata0"}, 32'(rdata0), 32'(d0));
    chk({tag, " rdata1"}, 32'(rdata1), 32'(d1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read order during the concurrent phase: 0x20..0x27, then the accepted writes 0x31...
  function automatic logic [7:0] rs(input int n);
    return (n < 8) ? 8'(8'h20 + n) : 8'(8'h29 + n);
  endfunction

  initial begin
    lvl_fl = '{8'h0A, 8'h06, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20, 8'h60, 8'hA0};
    rst = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    step();
    step();
    chk_state("reset", 4'd0, 8'h0A);
    chk_data("reset", 8'h00, 8'h00);
    rst = 1'b0;
    step();

    // 1: fill with 0x10..0x17
    wen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'(8'h10 + i);
      step();
      chk_state("fill", 4'(i + 1), lvl_fl[i + 1]);
      chk_data("fill", 8'h00, 8'h10);
    end

    // 2: write while full
    wdata = 8'hAA;
    step();
    chk_state("overrun", 4'd8, 8'hB0);
    wen = 1'b0;
    step();
    chk_state("overrun hold", 4'd8, 8'hB0);

    // 3: drain, then one read too many
    ren = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_state("drain", 4'(8 - k), lvl_fl[8 - k] | 8'h10);
      chk_data("drain", 8'(8'h10 + k - 1), (k < 8) ? 8'(8'h10 + k) : 8'h00);
    end
    step();
    chk_state("underrun", 4'd0, 8'h1B);
    chk_data("underrun", 8'h17, 8'h00);
    ren = 1'b0;

    // 4: refill, then concurrent read/write across two pointer wraps
    wen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'(8'h20 + i);
      step();
      chk_state("refill", 4'(i + 1), lvl_fl[i + 1] | 8'h11);
      chk_data("refill", 8'h17, 8'h20);
    end
    ren = 1'b1;
    for (int c = 0; c < 20; c++) begin
      wdata = 8'(8'h30 + c);
      step();
      chk_state("rw", 4'd7, 8'h71);
      chk_data("rw", rs(c), rs(c + 1));
    end

    // 5: down to level 5, then flush with a write pending
    wen = 1'b0;
    step();
    chk_state("pre-flush", 4'd6, 8'h31);
    chk_data("pre-flush", 8'h3D, 8'h3E);
    step();
    chk_state("pre-flush", 4'd5, 8'h11);
    chk_data("pre-flush", 8'h3E, 8'h3F);
    ren = 1'b0; flush = 1'b1; wen = 1'b1; wdata = 8'h99;
    step();
    chk_state("flush", 4'd0, 8'h0A);
    chk_data("flush", 8'h00, 8'h00);
    flush = 1'b0; wen = 1'b0;
    step();
    chk_state("post-flush", 4'd0, 8'h0A);
    wen = 1'b1; wdata = 8'h55;
    step();
    chk_state("w55", 4'd1, 8'h06);
    chk_data("w55", 8'h00, 8'h55);
    wen = 1'b0; ren = 1'b1;
    step();
    chk_state("r55", 4'd0, 8'h0A);
    chk_data("r55", 8'h55, 8'h00);
    ren = 1'b0;

    // 6: async reset mid-clock at level 4
    wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = 8'(8'h60 + i);
      step();
    end
    wen = 1'b0;
    chk_state("pre-rst", 4'd4, 8'h00);
    chk_data("pre-rst", 8'h55, 8'h60);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async rst", 4'd0, 8'h0A);
    chk_data("async rst", 8'h00, 8'h00);
    step();
    rst = 1'b0;
    wen = 1'b1; wdata = 8'h70;
    step();
    chk_state("post-rst w", 4'd1, 8'h06);
    chk_data("post-rst w", 8'h00, 8'h70);
    wen = 1'b0; ren = 1'b1;
    step();
    chk_state("post-rst r", 4'd0, 8'h0A);
    chk_data("post-rst r", 8'h70, 8'h00);
    ren = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
